// File: rtl/host_monitor.sv
// Simulation host monitor: watches data-side stores for program exit and console output,
// tracks run cycles and buffers console bytes in a small show-ahead FIFO.
module host_monitor #(
    parameter int                XLEN           = 32,
    parameter logic [XLEN-1:0]   EXIT_ADDR      = 'h0,
    parameter logic [XLEN-1:0]   CONSOLE_ADDR   = 'h4,
    parameter int unsigned       TIMEOUT_CYCLES = 1000000,
    parameter int                CONS_DEPTH     = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            w_v,
    input  logic [XLEN-1:0] data_adr,
    input  logic [XLEN-1:0] data_i,
    input  logic [3:0]      strobe,
    input  logic            cons_rd,
    output logic [7:0]      cons_data,
    output logic            cons_empty,
    output logic            cons_full,
    output logic [15:0]     cons_drop,
    output logic            done,
    output logic            pass,
    output logic            timeout,
    output logic [XLEN-1:0] exit_code,
    output logic [31:0]     cycle_cnt,
    output logic [31:0]     store_cnt
);

    // state     | meaning
    // RUN       | program executing, counters live, console stores accepted
    // EXITED    | exit store seen; counters frozen until reset
    // TIMED_OUT | cycle budget exhausted; counters frozen until reset
    typedef enum logic [1:0] {RUN, EXITED, TIMED_OUT} state_e;

    localparam int PW = $clog2(CONS_DEPTH);

    state_e          state_q;
    logic            done_q, pass_q, timeout_q;
    logic [XLEN-1:0] exit_code_q;
    logic [31:0]     cycle_cnt_q, store_cnt_q;

    logic            running, exit_store, tc_hit;

    assign running    = (state_q == RUN);
    assign exit_store = w_v && (data_adr == EXIT_ADDR) && (strobe != 4'b0000);
    assign tc_hit     = (cycle_cnt_q == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            exit_code_q <= '0;
            cycle_cnt_q <= '0;
            store_cnt_q <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    cycle_cnt_q <= cycle_cnt_q + 32'd1;
                    if (w_v) store_cnt_q <= store_cnt_q + 32'd1;
                    // exit store takes priority over a coincident timeout
                    if (exit_store) begin
                        state_q     <= EXITED;
                        exit_code_q <= data_i;
                        done_q      <= 1'b1;
                        pass_q      <= (data_i == '0);
                    end else if (tc_hit) begin
                        state_q     <= TIMED_OUT;
                        exit_code_q <= '1;
                        done_q      <= 1'b1;
                        timeout_q   <= 1'b1;
                        pass_q      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    logic [7:0]    mem_q [CONS_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [15:0]   drop_q, drop_d;
    logic          cons_store, push, pop, drop, fifo_empty, fifo_full;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (PW+1)'(CONS_DEPTH));
    assign cons_store = running && w_v && (data_adr == CONSOLE_ADDR) && strobe[0];
    assign pop        = cons_rd && !fifo_empty;
    assign push       = cons_store && (!fifo_full || pop);
    assign drop       = cons_store && fifo_full && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
        if (drop && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    // storage needs no reset: the pointers alone define valid contents
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= data_i[7:0];
    end

    assign cons_data  = mem_q[rd_ptr_q];
    assign cons_empty = fifo_empty;
    assign cons_full  = fifo_full;
    assign cons_drop  = drop_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign timeout    = timeout_q;
    assign exit_code  = exit_code_q;
    assign cycle_cnt  = cycle_cnt_q;
    assign store_cnt  = store_cnt_q;

endmodule

// File: tb/tb_host_monitor.sv
// Self-checking bench for host_monitor: a run-status model plus a console-byte
// scoreboard filled on console stores and drained on pops.
module tb_host_monitor;

    localparam int XLEN  = 32;
    localparam int DEPTH = 8;
    localparam int TO    = 50;

    logic            clk = 1'b0;
    logic            rst;
    logic            w_v;
    logic [XLEN-1:0] data_adr;
    logic [XLEN-1:0] data_i;
    logic [3:0]      strobe;
    logic            cons_rd;
    logic [7:0]      cons_data;
    logic            cons_empty, cons_full;
    logic [15:0]     cons_drop;
    logic            done, pass, timeout;
    logic [XLEN-1:0] exit_code;
    logic [31:0]     cycle_cnt, store_cnt;

    always #5 clk = ~clk;

    host_monitor #(
        .XLEN(XLEN), .EXIT_ADDR(32'h0), .CONSOLE_ADDR(32'h4),
        .TIMEOUT_CYCLES(TO), .CONS_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .w_v(w_v), .data_adr(data_adr), .data_i(data_i),
        .strobe(strobe), .cons_rd(cons_rd), .cons_data(cons_data),
        .cons_empty(cons_empty), .cons_full(cons_full), .cons_drop(cons_drop),
        .done(done), .pass(pass), .timeout(timeout), .exit_code(exit_code),
        .cycle_cnt(cycle_cnt), .store_cnt(store_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    logic [7:0]  sb_q[$];
    int          m_state;
    logic [31:0] m_cyc, m_stores, m_code;
    logic        m_done, m_pass, m_to;
    logic [15:0] m_drop;

    task automatic model_reset();
        sb_q.delete();
        m_state = 0; m_cyc = 0; m_stores = 0; m_code = 0;
        m_done = 0; m_pass = 0; m_to = 0; m_drop = 0;
    endtask

    task automatic check_all(input string t);
        chk({t, "_done"}, done, m_done);
        chk({t, "_pass"}, pass, m_pass);
        chk({t, "_timeout"}, timeout, m_to);
        chk({t, "_exit_code"}, exit_code, m_code);
        chk({t, "_cycle_cnt"}, cycle_cnt, m_cyc);
        chk({t, "_store_cnt"}, store_cnt, m_stores);
        chk({t, "_cons_drop"}, cons_drop, m_drop);
        chk({t, "_cons_empty"}, cons_empty, sb_q.size() == 0);
        chk({t, "_cons_full"}, cons_full, sb_q.size() == DEPTH);
        if (sb_q.size() > 0) chk({t, "_head"}, cons_data, sb_q[0]);
    endtask

    // one clock: drive, score pops before the edge, advance the model, then step
    task automatic cycle(input logic wv, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] strb, input logic rd);
        w_v = wv; data_adr = adr; data_i = dat; strobe = strb; cons_rd = rd;
        if (rd) begin
            if (sb_q.size() > 0) chk("pop_data", cons_data, sb_q.pop_front());
            else                 chk("pop_on_empty", cons_empty, 1);
        end
        if (m_state == 0 && wv && adr == 32'h4 && strb[0]) begin
            if (sb_q.size() < DEPTH) sb_q.push_back(dat[7:0]);
            else if (m_drop != 16'hFFFF) m_drop++;
        end
        if (m_state == 0) begin
            if (wv && adr == 32'h0 && strb != 4'h0) begin
                m_state = 1; m_code = dat; m_done = 1; m_pass = (dat == 0);
            end else if (m_cyc == TO - 1) begin
                m_state = 2; m_code = 32'hFFFF_FFFF; m_done = 1; m_to = 1; m_pass = 0;
            end
            if (wv) m_stores++;
            m_cyc++;
        end
        @(posedge clk); #1;
        w_v = 0; cons_rd = 0; strobe = 4'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1; w_v = 0; data_adr = 0; data_i = 0; strobe = 0; cons_rd = 0;
        model_reset();
        #1;
        check_all("rst");
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        #2;
        do_reset();

        // exit with code 0 at cycle 10, then everything frozen
        idle(10);
        chk("pre_exit_cycle", cycle_cnt, 32'd10);
        cycle(1'b1, 32'h0, 32'h0, 4'hF, 1'b0);
        chk("exit0_done", done, 1);
        chk("exit0_pass", pass, 1);
        chk("exit0_code", exit_code, 32'h0);
        chk("exit0_cycle", cycle_cnt, 32'd11);
        chk("exit0_timeout", timeout, 0);
        check_all("exit0");
        cycle(1'b1, 32'h4, 32'h41, 4'h1, 1'b0);
        cycle(1'b1, 32'h0, 32'h5, 4'hF, 1'b0);
        idle(3);
        chk("frozen_cycle", cycle_cnt, 32'd11);
        chk("frozen_stores", store_cnt, 32'd1);
        chk("frozen_code", exit_code, 32'h0);
        chk("frozen_no_console", cons_empty, 1);
        check_all("frozen");

        // exit with a nonzero code
        do_reset();
        idle(4);
        cycle(1'b1, 32'h0, 32'h3, 4'h1, 1'b0);
        chk("exit3_pass", pass, 0);
        chk("exit3_code", exit_code, 32'h3);
        chk("exit3_timeout", timeout, 0);
        check_all("exit3");

        // timeout with no exit store
        do_reset();
        idle(TO - 1);
        chk("pre_to_done", done, 0);
        idle(1);
        chk("to_done", done, 1);
        chk("to_timeout", timeout, 1);
        chk("to_pass", pass, 0);
        chk("to_code", exit_code, 32'hFFFF_FFFF);
        chk("to_cycle", cycle_cnt, 32'd50);
        idle(5);
        chk("to_frozen_cycle", cycle_cnt, 32'd50);
        check_all("to");

        // exit store on the timeout cycle wins
        do_reset();
        idle(TO - 1);
        cycle(1'b1, 32'h0, 32'h0, 4'hF, 1'b0);
        chk("race_timeout", timeout, 0);
        chk("race_pass", pass, 1);
        chk("race_cycle", cycle_cnt, 32'd50);
        check_all("race");

        // "ABC" in order
        do_reset();
        cycle(1'b1, 32'h4, 32'h141, 4'h1, 1'b0);
        cycle(1'b1, 32'h4, 32'h42, 4'h1, 1'b0);
        cycle(1'b1, 32'h4, 32'h43, 4'h1, 1'b0);
        chk("abc_head_A", cons_data, 32'h41);
        cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        chk("abc_head_B", cons_data, 32'h42);
        cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        chk("abc_head_C", cons_data, 32'h43);
        cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        chk("abc_empty", cons_empty, 1);
        check_all("abc");

        // overflow, push+pop while full, drain, pop while empty
        do_reset();
        for (int i = 0; i < DEPTH + 3; i++) cycle(1'b1, 32'h4, 32'h60 + i, 4'h1, 1'b0);
        chk("ovf_full", cons_full, 1);
        chk("ovf_drop", cons_drop, 32'd3);
        chk("ovf_head", cons_data, 32'h60);
        cycle(1'b1, 32'h4, 32'h7E, 4'h1, 1'b1);
        chk("full_pp_full", cons_full, 1);
        chk("full_pp_drop", cons_drop, 32'd3);
        check_all("full_pp");
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        chk("drained_empty", cons_empty, 1);
        cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        check_all("empty_pop");

        // push+pop while empty: push only, visible next cycle
        cycle(1'b1, 32'h4, 32'h5A, 4'h1, 1'b1);
        chk("empty_pp_nonempty", cons_empty, 0);
        chk("empty_pp_data", cons_data, 32'h5A);
        check_all("empty_pp");

        // async reset with bytes queued after EXITED, then a fresh run
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'h4, 32'h30 + i, 4'h1, 1'b0);
        cycle(1'b1, 32'h0, 32'h7, 4'hF, 1'b0);
        chk("pre_rst_done", done, 1);
        chk("pre_rst_queued", cons_empty, 0);
        w_v = 1; data_adr = 32'h4; data_i = 32'h99; strobe = 4'h1;
        rst = 1'b1;
        #2;
        model_reset();
        check_all("async_rst");
        @(posedge clk); #1;
        w_v = 0; strobe = 4'h0;
        rst = 1'b0;
        idle(3);
        cycle(1'b1, 32'h4, 32'h42, 4'h1, 1'b0);
        idle(5);
        chk("fresh_cycle", cycle_cnt, 32'd9);
        cycle(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        cycle(1'b1, 32'h0, 32'h0, 4'hF, 1'b0);
        chk("fresh_done", done, 1);
        chk("fresh_pass", pass, 1);
        chk("fresh_exit_cycle", cycle_cnt, 32'd11);
        check_all("fresh");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
